// File: rtl/rs.sv
// rs: unified reservation station with CDB tag wakeup and per-FU-type lowest-row issue
package rs_pkg;
  typedef enum logic [2:0] {FU_ALU, FU_LD, FU_ST, FU_MULT, FU_BR} fu_t;
  typedef struct packed {
    logic [31:0] inst;
    fu_t         fu_name;
    logic        valid_inst;
  } inst_t;
  typedef struct packed {
    inst_t      inst;
    logic [6:0] T;
    logic [6:0] T1;
    logic [6:0] T2;
    logic       busy;
  } rs_row_t;
endpackage

module rs
  import rs_pkg::*;
#(
  parameter int RS_SIZE = 16,
  parameter int NUM_FU  = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         CAM_en,
  input  logic [6:0]                   CDB_in,
  input  logic                         dispatch_valid,
  input  rs_row_t                      inst_in,
  input  logic [1:0]                   LSQ_busy,
  output rs_row_t [RS_SIZE-1:0]        rs_table_out,
  output logic [RS_SIZE-1:0]           issue_idx,
  output rs_row_t [NUM_FU-1:0]         issue_out,
  output logic [$clog2(NUM_FU)-1:0]    issue_cnt,
  output logic                         rs_full
);
  localparam int CW = $clog2(NUM_FU);
  localparam int IW = $clog2(RS_SIZE);
  rs_row_t [RS_SIZE-1:0] table_q, table_d;
  rs_row_t din;
  logic [RS_SIZE-1:0] rdy, busy;
  logic [IW-1:0] free_idx;
  logic taken;
  function automatic rs_row_t wake(rs_row_t r, logic en, logic [6:0] cdb);
    wake = r;
    if (en && r.T1[5:0] == cdb[5:0]) wake.T1[6] = 1'b1;
    if (en && r.T2[5:0] == cdb[5:0]) wake.T2[6] = 1'b1;
  endfunction
  assign rs_table_out = table_q;
  assign rs_full = &busy;
  assign issue_cnt = CW'($countones(issue_idx));
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy[i] = table_q[i].busy;
      rdy[i] = enable && reset && table_q[i].busy && table_q[i].T1[6] && table_q[i].T2[6];
    end
  end
  // taken starts set for a memory FU whose queue is busy, so nothing is selected for it
  always_comb begin
    issue_out = '0;
    issue_idx = '0;
    taken = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      taken = (k == int'(FU_LD) && LSQ_busy[0]) || (k == int'(FU_ST) && LSQ_busy[1]);
      for (int i = 0; i < RS_SIZE; i++)
        if (!taken && rdy[i] && table_q[i].inst.fu_name == fu_t'(k)) begin
          taken = 1'b1;
          issue_out[k] = table_q[i];
          issue_idx[i] = 1'b1;
        end
    end
  end
  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) if (!table_q[i].busy) free_idx = IW'(i);
    din = wake(inst_in, CAM_en, CDB_in);
    din.busy = 1'b1;
    table_d = table_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (table_q[i].busy) table_d[i] = wake(table_q[i], CAM_en, CDB_in);
      if (issue_idx[i]) table_d[i].busy = 1'b0;
    end
    if (dispatch_valid && inst_in.inst.valid_inst && !rs_full) table_d[free_idx] = din;
  end
  always_ff @(posedge clock)
    if (!reset) table_q <= '0;
    else if (enable) table_q <= table_d;
endmodule

// File: tb/tb_rs.sv
// tb_rs: directed self-checking bench for the reservation station
module tb_rs;
  import rs_pkg::*;
  logic clock = 0, reset = 0, enable = 1, CAM_en = 0, dispatch_valid = 0;
  logic [6:0] CDB_in = '0;
  logic [1:0] LSQ_busy = '0;
  rs_row_t inst_in = '0;
  rs_row_t [15:0] rs_table_out;
  logic [15:0] issue_idx, bv;
  rs_row_t [4:0] issue_out;
  logic [2:0] issue_cnt;
  logic rs_full;
  int checks = 0, failures = 0;

  rs dut (
    .clock(clock), .reset(reset), .enable(enable), .CAM_en(CAM_en), .CDB_in(CDB_in),
    .dispatch_valid(dispatch_valid), .inst_in(inst_in), .LSQ_busy(LSQ_busy),
    .rs_table_out(rs_table_out), .issue_idx(issue_idx), .issue_out(issue_out),
    .issue_cnt(issue_cnt), .rs_full(rs_full)
  );

  always #5 clock = ~clock;
  always_comb for (int i = 0; i < 16; i++) bv[i] = rs_table_out[i].busy;

  function automatic rs_row_t mk(fu_t f, logic [6:0] t, logic [6:0] t1, logic [6:0] t2);
    mk = '0;
    mk.inst.fu_name = f;
    mk.inst.valid_inst = 1'b1;
    mk.T = t;
    mk.T1 = t1;
    mk.T2 = t2;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic disp(rs_row_t r);
    inst_in = r;
    dispatch_valid = 1;
    tick();
    dispatch_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
    checks++; if (bv !== 16'h0) begin failures++; $display("FAIL reset_busy got %h exp 0000", bv); end
    checks++; if (issue_out !== '0) begin failures++; $display("FAIL reset_issue_out got %h exp 0", issue_out); end
    checks++; if (issue_idx !== 16'h0) begin failures++; $display("FAIL reset_issue_idx got %h exp 0000", issue_idx); end
    checks++; if (issue_cnt !== 3'd0) begin failures++; $display("FAIL reset_issue_cnt got %0d exp 0", issue_cnt); end
    checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL reset_full got %b exp 0", rs_full); end
  endtask

  task automatic test_mult();
    disp(mk(FU_MULT, 7'd3, 7'b1000001, 7'b1000010));
    checks++; if (rs_table_out[0].busy !== 1'b1) begin failures++; $display("FAIL mult_row0_busy got %b exp 1", rs_table_out[0].busy); end
    checks++; if (issue_out[FU_MULT].T !== 7'd3) begin failures++; $display("FAIL mult_issue_T got %0d exp 3", issue_out[FU_MULT].T); end
    checks++; if (issue_out[FU_MULT].busy !== 1'b1) begin failures++; $display("FAIL mult_issue_busy got %b exp 1", issue_out[FU_MULT].busy); end
    checks++; if (issue_idx !== 16'h0001) begin failures++; $display("FAIL mult_issue_idx got %h exp 0001", issue_idx); end
    checks++; if (issue_cnt !== 3'd1) begin failures++; $display("FAIL mult_issue_cnt got %0d exp 1", issue_cnt); end
    tick();
    checks++; if (bv !== 16'h0) begin failures++; $display("FAIL mult_cleared got %h exp 0000", bv); end
  endtask

  task automatic test_back_to_back();
    disp(mk(FU_BR, 7'd4, 7'h7f, 7'h7f));
    checks++; if (issue_out[FU_BR].T !== 7'd4) begin failures++; $display("FAIL b2b_br_T got %0d exp 4", issue_out[FU_BR].T); end
    checks++; if (issue_idx !== 16'h0001) begin failures++; $display("FAIL b2b_br_idx got %h exp 0001", issue_idx); end
    disp(mk(FU_LD, 7'd5, 7'h7f, 7'b1000001));
    checks++; if (issue_idx !== 16'h0002) begin failures++; $display("FAIL b2b_ld_idx got %h exp 0002", issue_idx); end
    checks++; if (issue_out[FU_LD].T !== 7'd5) begin failures++; $display("FAIL b2b_ld_T got %0d exp 5", issue_out[FU_LD].T); end
    disp(mk(FU_LD, 7'd6, 7'h7f, 7'b1000001));
    LSQ_busy = 2'b01;
    #1;
    checks++; if (issue_idx !== 16'h0) begin failures++; $display("FAIL b2b_ld_blocked got %h exp 0000", issue_idx); end
    checks++; if (rs_table_out[0].T !== 7'd6) begin failures++; $display("FAIL b2b_ld_row0 got %0d exp 6", rs_table_out[0].T); end
    tick();
    checks++; if (bv !== 16'h0001) begin failures++; $display("FAIL b2b_ld_held got %h exp 0001", bv); end
    checks++; if (issue_out[FU_LD] !== '0) begin failures++; $display("FAIL b2b_ld_out_zero got %h exp 0", issue_out[FU_LD]); end
    LSQ_busy = 2'b00;
    #1;
    checks++; if (issue_out[FU_LD].T !== 7'd6) begin failures++; $display("FAIL b2b_ld_release got %0d exp 6", issue_out[FU_LD].T); end
    tick();
    checks++; if (bv !== 16'h0) begin failures++; $display("FAIL b2b_empty got %h exp 0000", bv); end
  endtask

  task automatic test_cam();
    disp(mk(FU_ST, 7'd7, 7'b0000001, 7'b0000110));
    tick();
    checks++; if (issue_idx !== 16'h0 || bv !== 16'h0001) begin failures++; $display("FAIL cam_wait got idx=%h busy=%h exp 0000/0001", issue_idx, bv); end
    CAM_en = 1;
    CDB_in = 7'd1;
    tick();
    CAM_en = 0;
    checks++; if (rs_table_out[0].T1 !== 7'h41) begin failures++; $display("FAIL cam_t1 got %h exp 41", rs_table_out[0].T1); end
    checks++; if (rs_table_out[0].T2 !== 7'h06 || issue_idx !== 16'h0) begin failures++; $display("FAIL cam_t2_wait got t2=%h idx=%h exp 06/0000", rs_table_out[0].T2, issue_idx); end
    CAM_en = 1;
    CDB_in = 7'd6;
    tick();
    CAM_en = 0;
    checks++; if (issue_out[FU_ST].T !== 7'd7 || issue_idx !== 16'h0001) begin failures++; $display("FAIL cam_issue got T=%0d idx=%h exp 7/0001", issue_out[FU_ST].T, issue_idx); end
    tick();
    CAM_en = 1;
    CDB_in = 7'd2;
    disp(mk(FU_ALU, 7'd9, 7'b0000010, 7'h7f));
    CAM_en = 0;
    checks++; if (rs_table_out[0].T1 !== 7'h42 || issue_out[FU_ALU].T !== 7'd9) begin failures++; $display("FAIL cam_dispatch_wake got t1=%h T=%0d exp 42/9", rs_table_out[0].T1, issue_out[FU_ALU].T); end
    tick();
    checks++; if (bv !== 16'h0) begin failures++; $display("FAIL cam_empty got %h exp 0000", bv); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) disp(mk(FU_ALU, 7'(i), 7'(16 + i), 7'h7f));
    checks++; if (rs_full !== 1'b1 || bv !== 16'hffff) begin failures++; $display("FAIL full_set got full=%b busy=%h exp 1/ffff", rs_full, bv); end
    disp(mk(FU_ALU, 7'h63, 7'h7f, 7'h7f));
    checks++; if (issue_idx !== 16'h0) begin failures++; $display("FAIL full_drop got %h exp 0000", issue_idx); end
    CAM_en = 1;
    CDB_in = 7'h15;
    tick();
    CAM_en = 0;
    checks++; if (issue_idx !== 16'h0020 || rs_full !== 1'b1) begin failures++; $display("FAIL full_wake got idx=%h full=%b exp 0020/1", issue_idx, rs_full); end
    tick();
    checks++; if (rs_full !== 1'b0 || bv !== 16'hffdf) begin failures++; $display("FAIL full_freed got full=%b busy=%h exp 0/ffdf", rs_full, bv); end
    disp(mk(FU_MULT, 7'h2a, 7'h30, 7'h7f));
    checks++; if (rs_table_out[5].T !== 7'h2a || rs_full !== 1'b1) begin failures++; $display("FAIL full_refill got T=%h full=%b exp 2a/1", rs_table_out[5].T, rs_full); end
  endtask

  task automatic test_mid_reset();
    reset = 0;
    tick();
    reset = 1;
    checks++; if (rs_table_out !== '0 || rs_full !== 1'b0) begin failures++; $display("FAIL mid_reset got busy=%h full=%b exp 0000/0", bv, rs_full); end
  endtask

  task automatic test_dual();
    disp(mk(FU_ALU, 7'd1, 7'h21, 7'h7f));
    disp(mk(FU_ALU, 7'd2, 7'h21, 7'h7f));
    disp(mk(FU_MULT, 7'd3, 7'h21, 7'h7f));
    CAM_en = 1;
    CDB_in = 7'h21;
    tick();
    CAM_en = 0;
    checks++; if (issue_idx !== 16'h0005 || issue_cnt !== 3'd2) begin failures++; $display("FAIL dual_sel got idx=%h cnt=%0d exp 0005/2", issue_idx, issue_cnt); end
    checks++; if (issue_out[FU_ALU].T !== 7'd1 || issue_out[FU_MULT].T !== 7'd3) begin failures++; $display("FAIL dual_out got alu=%0d mult=%0d exp 1/3", issue_out[FU_ALU].T, issue_out[FU_MULT].T); end
    tick();
    checks++; if (issue_idx !== 16'h0002 || issue_cnt !== 3'd1) begin failures++; $display("FAIL dual_second got idx=%h cnt=%0d exp 0002/1", issue_idx, issue_cnt); end
    tick();
    checks++; if (bv !== 16'h0) begin failures++; $display("FAIL dual_empty got %h exp 0000", bv); end
  endtask

  task automatic test_enable();
    disp(mk(FU_ALU, 7'd8, 7'h7f, 7'h7f));
    enable = 0;
    inst_in = mk(FU_ALU, 7'd10, 7'h7f, 7'h7f);
    dispatch_valid = 1;
    CAM_en = 1;
    CDB_in = 7'h05;
    #1;
    checks++; if (issue_idx !== 16'h0 || issue_cnt !== 3'd0 || issue_out !== '0) begin failures++; $display("FAIL en_issue got idx=%h cnt=%0d exp 0000/0", issue_idx, issue_cnt); end
    tick();
    tick();
    dispatch_valid = 0;
    CAM_en = 0;
    checks++; if (bv !== 16'h0001 || rs_table_out[0].T !== 7'd8) begin failures++; $display("FAIL en_hold got busy=%h T=%0d exp 0001/8", bv, rs_table_out[0].T); end
    enable = 1;
    #1;
    checks++; if (issue_idx !== 16'h0001) begin failures++; $display("FAIL en_resume got %h exp 0001", issue_idx); end
    tick();
    checks++; if (bv !== 16'h0) begin failures++; $display("FAIL en_empty got %h exp 0000", bv); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_cam();
    test_full();
    test_mid_reset();
    test_dual();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
